// File: rtl/eth_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_test_pkg
// Description : Shared types and constants for the Ethernet PRBS test path.
//               Holds the payload-generator state encoding, the LFSR word
//               width, the sequence-number prefix size and the XNOR-LFSR
//               lockup value.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_test_pkg;

    localparam int LFSR_W    = 32;
    localparam int SEQ_BYTES = 2;

    // An XNOR-feedback LFSR never leaves the all-ones state.
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SEQ_HI  = 3'd2,
        ST_SEQ_LO  = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_GAP     = 3'd5
    } gen_state_t;

    // Replace the lockup seed by all-zeros so the sequence always advances.
    function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] seed);
        return (seed == LFSR_LOCKUP) ? '0 : seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_payload_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_payload_gen
// Description : PRBS test-frame payload generator. Seeds and steps an external
//               32-bit XNOR LFSR, serialises its words MSB-first into a byte
//               stream with a 16-bit sequence-number prefix and a last-byte
//               marker, and inserts a fixed idle gap between frames.
// Revision    : 1.0 - initial release
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_enable           frames run back-to-back while high
//   i_seed             LFSR seed, captured when leaving IDLE
//   i_payload_len      PRBS bytes per frame (sequence bytes excluded)
//   o_lfsr_rst_seed    one-cycle seed-load strobe to the LFSR
//   o_lfsr_enable      one-cycle step strobe to the LFSR
//   o_lfsr_seed        captured seed to the LFSR
//   i_lfsr_data        current LFSR word
//   o_tdata/o_tvalid/i_tready/o_tlast   byte stream with handshake
//   o_busy             high whenever not IDLE
//   o_frame_count      completed frames, wraps at 16 bits
// ============================================================================
module lfsr_payload_gen
    import eth_test_pkg::*;
#(
    parameter int LEN_W      = 11,
    parameter int GAP_CYCLES = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [LFSR_W-1:0]     i_seed,
    input  logic [LEN_W-1:0]      i_payload_len,
    output logic                  o_lfsr_rst_seed,
    output logic                  o_lfsr_enable,
    output logic [LFSR_W-1:0]     o_lfsr_seed,
    input  logic [LFSR_W-1:0]     i_lfsr_data,
    output logic [7:0]            o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic [SEQ_BYTES*8-1:0] o_frame_count
);

    localparam int               c_SEQ_W    = SEQ_BYTES * 8;
    localparam int               c_GAP_W    = $clog2(GAP_CYCLES + 1);
    // Counting down to zero inclusive gives exactly GAP_CYCLES idle cycles.
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

    gen_state_t          r_state,         w_state_nxt;
    logic [LFSR_W-1:0]   r_seed,          w_seed_nxt;
    logic [LEN_W-1:0]    r_len,           w_len_nxt;
    logic [LEN_W-1:0]    r_remain,        w_remain_nxt;
    logic [1:0]          r_byte_idx,      w_byte_idx_nxt;
    logic [c_GAP_W-1:0]  r_gap_cnt,       w_gap_cnt_nxt;
    logic [LFSR_W-1:0]   r_word,          w_word_nxt;
    logic [7:0]          r_tdata,         w_tdata_nxt;
    logic                r_tvalid,        w_tvalid_nxt;
    logic                r_tlast,         w_tlast_nxt;
    logic                r_busy,          w_busy_nxt;
    logic                r_lfsr_rst_seed, w_lfsr_rst_seed_nxt;
    logic                r_lfsr_enable,   w_lfsr_enable_nxt;
    logic [c_SEQ_W-1:0]  r_frame_count,   w_frame_count_nxt;

    logic                w_hs;
    logic [1:0]          w_idx_inc;
    logic [7:0]          w_next_byte;
    logic                w_load_word;
    logic                w_enter_seq;
    logic                w_finish;

    assign w_hs        = r_tvalid & i_tready;
    assign w_idx_inc   = r_byte_idx + 2'd1;
    // Byte k of the word (MSB-first) lives at bit offset 8*(3-k); ~k == 3-k.
    assign w_next_byte = r_word[{~w_idx_inc, 3'b000} +: 8];

    always_comb begin
        w_state_nxt         = r_state;
        w_seed_nxt          = r_seed;
        w_len_nxt           = r_len;
        w_remain_nxt        = r_remain;
        w_byte_idx_nxt      = r_byte_idx;
        w_gap_cnt_nxt       = r_gap_cnt;
        w_word_nxt          = r_word;
        w_tdata_nxt         = r_tdata;
        w_tvalid_nxt        = r_tvalid;
        w_tlast_nxt         = r_tlast;
        w_frame_count_nxt   = r_frame_count;
        w_lfsr_rst_seed_nxt = 1'b0;
        w_lfsr_enable_nxt   = 1'b0;
        w_load_word         = 1'b0;
        w_enter_seq         = 1'b0;
        w_finish            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_seed_nxt          = safe_seed(i_seed);
                    w_lfsr_rst_seed_nxt = 1'b1;
                    w_state_nxt         = ST_SEED;
                end
            end
            ST_SEED: begin
                w_enter_seq = 1'b1;
            end
            ST_SEQ_HI: begin
                if (w_hs) begin
                    w_state_nxt = ST_SEQ_LO;
                    w_tdata_nxt = r_frame_count[7:0];
                    w_tlast_nxt = (r_len == '0);
                end
            end
            ST_SEQ_LO: begin
                if (w_hs) begin
                    if (r_len == '0) begin
                        w_finish = 1'b1;
                    end else begin
                        w_load_word  = 1'b1;
                        w_remain_nxt = r_len;
                        w_tlast_nxt  = (r_len == LEN_W'(1));
                        w_state_nxt  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_finish = 1'b1;
                    end else begin
                        // r_remain counts the byte on the bus plus those after it.
                        w_remain_nxt = r_remain - LEN_W'(1);
                        w_tlast_nxt  = (r_remain == LEN_W'(2));
                        if (r_byte_idx == 2'd3) begin
                            w_load_word = 1'b1;
                        end else begin
                            w_byte_idx_nxt = w_idx_inc;
                            w_tdata_nxt    = w_next_byte;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    if (i_enable) begin
                        w_enter_seq = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // The word is taken now and the LFSR steps one cycle later, so the
        // following word has settled well before byte 3 of this one is sent.
        if (w_load_word) begin
            w_word_nxt        = i_lfsr_data;
            w_tdata_nxt       = i_lfsr_data[LFSR_W-1 -: 8];
            w_byte_idx_nxt    = 2'd0;
            w_lfsr_enable_nxt = 1'b1;
        end

        if (w_finish) begin
            w_frame_count_nxt = r_frame_count + c_SEQ_W'(1);
            w_tvalid_nxt      = 1'b0;
            w_tlast_nxt       = 1'b0;
            w_tdata_nxt       = 8'h00;
            w_gap_cnt_nxt     = c_GAP_LOAD;
            w_state_nxt       = ST_GAP;
        end

        if (w_enter_seq) begin
            w_len_nxt    = i_payload_len;
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = r_frame_count[c_SEQ_W-1 -: 8];
            w_tlast_nxt  = 1'b0;
            w_state_nxt  = ST_SEQ_HI;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_seed          <= '0;
            r_len           <= '0;
            r_remain        <= '0;
            r_byte_idx      <= '0;
            r_gap_cnt       <= '0;
            r_word          <= '0;
            r_tdata         <= '0;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_busy          <= 1'b0;
            r_lfsr_rst_seed <= 1'b0;
            r_lfsr_enable   <= 1'b0;
            r_frame_count   <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_seed          <= w_seed_nxt;
            r_len           <= w_len_nxt;
            r_remain        <= w_remain_nxt;
            r_byte_idx      <= w_byte_idx_nxt;
            r_gap_cnt       <= w_gap_cnt_nxt;
            r_word          <= w_word_nxt;
            r_tdata         <= w_tdata_nxt;
            r_tvalid        <= w_tvalid_nxt;
            r_tlast         <= w_tlast_nxt;
            r_busy          <= w_busy_nxt;
            r_lfsr_rst_seed <= w_lfsr_rst_seed_nxt;
            r_lfsr_enable   <= w_lfsr_enable_nxt;
            r_frame_count   <= w_frame_count_nxt;
        end
    end

    assign o_lfsr_rst_seed = r_lfsr_rst_seed;
    assign o_lfsr_enable   = r_lfsr_enable;
    assign o_lfsr_seed     = r_seed;
    assign o_tdata         = r_tdata;
    assign o_tvalid        = r_tvalid;
    assign o_tlast         = r_tlast;
    assign o_busy          = r_busy;
    assign o_frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_payload_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_payload_gen
// Description : Directed self-checking bench for lfsr_payload_gen, with a
//               behavioural 32-bit XNOR LFSR (taps 32,22,2,1) beside the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_payload_gen;

    localparam int LEN_W      = 11;
    localparam int GAP_CYCLES = 12;

    logic              i_clk   = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_enable = 1'b0;
    logic              i_tready = 1'b1;
    logic [31:0]       i_seed = '0;
    logic [LEN_W-1:0]  i_payload_len = '0;
    logic              o_lfsr_rst_seed;
    logic              o_lfsr_enable;
    logic [31:0]       o_lfsr_seed;
    logic [7:0]        o_tdata;
    logic              o_tvalid;
    logic              o_tlast;
    logic              o_busy;
    logic [15:0]       o_frame_count;
    logic [31:0]       r_lfsr = '0;

    int checks = 0;
    int errors = 0;
    logic [7:0] cap_data[$];
    bit         cap_last[$];

    always #5 i_clk = ~i_clk;

    lfsr_payload_gen #(
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_seed          (i_seed),
        .i_payload_len   (i_payload_len),
        .o_lfsr_rst_seed (o_lfsr_rst_seed),
        .o_lfsr_enable   (o_lfsr_enable),
        .o_lfsr_seed     (o_lfsr_seed),
        .i_lfsr_data     (r_lfsr),
        .o_tdata         (o_tdata),
        .o_tvalid        (o_tvalid),
        .i_tready        (i_tready),
        .o_tlast         (o_tlast),
        .o_busy          (o_busy),
        .o_frame_count   (o_frame_count)
    );

    // External LFSR model: shift left, XNOR feedback into bit 0.
    always @(posedge i_clk) begin
        if (o_lfsr_rst_seed)
            r_lfsr <= o_lfsr_seed;
        else if (o_lfsr_enable)
            r_lfsr <= {r_lfsr[30:0], ~(r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0])};
    end

    // Records accepted bytes starting at the current negedge; no checking here.
    task automatic capture(input int n, output int cycles, output bit ok);
        cap_data.delete();
        cap_last.delete();
        ok = 1'b1;
        cycles = 0;
        for (int cyc = 0; ; cyc++) begin
            if (o_tvalid && i_tready) begin
                cap_data.push_back(o_tdata);
                cap_last.push_back(o_tlast);
            end
            if (cap_data.size() >= n) begin
                cycles = cyc + 1;
                break;
            end
            if (cyc > 2000) begin
                ok = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    // Counts idle cycles after a frame until valid returns (max 40).
    task automatic count_idle(output int idle, output int busy_cnt);
        idle = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_tvalid) break;
            idle++;
            if (o_busy) busy_cnt++;
        end
    endtask

    task automatic pulse_enable(input logic [31:0] seed, input logic [LEN_W-1:0] len);
        @(negedge i_clk);
        i_seed = seed;
        i_payload_len = len;
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
    endtask

    task automatic test_reset;
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_lfsr_rst_seed, o_lfsr_enable, o_tdata, o_frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b l%b b%b rs%b en%b d%h fc%h required all zero",
                     o_tvalid, o_tlast, o_busy, o_lfsr_rst_seed, o_lfsr_enable, o_tdata, o_frame_count);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b valid %b required 0 0", o_busy, o_tvalid);
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp_b [12];
        int cycles, idle, busy_cnt;
        bit ok;
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        pulse_enable(32'h0000_0000, 11'd10);
        checks++;
        if (o_lfsr_rst_seed !== 1'b1 || o_lfsr_seed !== 32'h0 || o_tvalid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_seed_cycle: got rs %b seed %h valid %b busy %b required 1 00000000 0 1",
                     o_lfsr_rst_seed, o_lfsr_seed, o_tvalid, o_busy);
        end
        @(negedge i_clk);
        checks++;
        if (o_tvalid !== 1'b1 || o_lfsr_rst_seed !== 1'b0 || r_lfsr !== 32'h0 || o_tdata !== 8'h00) begin
            errors++;
            $display("FAIL basic_start_latency: got valid %b rs %b lfsr %h data %h required 1 0 00000000 00",
                     o_tvalid, o_lfsr_rst_seed, r_lfsr, o_tdata);
        end
        capture(12, cycles, ok);
        checks++;
        if (!ok || cycles !== 12) begin
            errors++;
            $display("FAIL basic_throughput: got %0d cycles (ok %b) required 12", cycles, ok);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap_data[i] !== exp_b[i] || cap_last[i] !== (i == 11)) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h last %b required %h last %b",
                         i, cap_data[i], cap_last[i], exp_b[i], (i == 11));
            end
        end
        count_idle(idle, busy_cnt);
        checks++;
        if (idle !== 40 || busy_cnt !== GAP_CYCLES || o_frame_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_end: got idle %0d busy %0d fc %h required 40 12 0001",
                     idle, busy_cnt, o_frame_count);
        end
    endtask

    task automatic test_lockup_seed;
        logic [7:0] exp_b [6];
        int cycles, idle, busy_cnt;
        bit ok;
        exp_b = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_enable(32'hFFFF_FFFF, 11'd4);
        checks++;
        if (o_lfsr_seed !== 32'h0000_0000 || o_lfsr_rst_seed !== 1'b1) begin
            errors++;
            $display("FAIL lockup_seed_sub: got seed %h rs %b required 00000000 1", o_lfsr_seed, o_lfsr_rst_seed);
        end
        capture(6, cycles, ok);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap_data[i] !== exp_b[i] || cap_last[i] !== (i == 5)) begin
                errors++;
                $display("FAIL lockup_byte%0d: got %h last %b required %h last %b",
                         i, cap_data[i], cap_last[i], exp_b[i], (i == 5));
            end
        end
        count_idle(idle, busy_cnt);
        checks++;
        if (o_frame_count !== 16'd2 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL lockup_end: got fc %h busy %b required 0002 0", o_frame_count, o_busy);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b [8];
        logic [15:0] pattern;
        logic [7:0] prev_data;
        bit prev_last, prev_stall;
        int n, idle, busy_cnt, guard;
        exp_b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h24, 8'h68};
        pattern = 16'b1011_0010_1101_0110;
        pulse_enable(32'h1234_5678, 11'd6);
        cap_data.delete();
        cap_last.delete();
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        n = 0;
        guard = 0;
        while (cap_data.size() < 8 && guard < 500) begin
            if (prev_stall) begin
                checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL bp_hold: got v%b %h l%b required v1 %h l%b",
                             o_tvalid, o_tdata, o_tlast, prev_data, prev_last);
                end
            end
            i_tready = pattern[n % 16] ^ ($urandom_range(0, 7) == 0);
            n++;
            if (o_tvalid && i_tready) begin
                cap_data.push_back(o_tdata);
                cap_last.push_back(o_tlast);
            end
            prev_stall = o_tvalid && !i_tready;
            prev_data = o_tdata;
            prev_last = o_tlast;
            if (cap_data.size() < 8) @(negedge i_clk);
            guard++;
        end
        checks++;
        if (cap_data.size() != 8) begin
            errors++;
            $display("FAIL bp_timeout: got %0d bytes required 8", cap_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap_data[i] !== exp_b[i] || cap_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h last %b required %h last %b",
                         i, cap_data[i], cap_last[i], exp_b[i], (i == 7));
            end
        end
        i_tready = 1'b1;
        count_idle(idle, busy_cnt);
        checks++;
        if (o_frame_count !== 16'd3) begin
            errors++;
            $display("FAIL bp_count: got %h required 0003", o_frame_count);
        end
    endtask

    task automatic test_enable_drop;
        logic [7:0] exp_b [8];
        int cycles, idle, busy_cnt;
        bit ok;
        logic [7:0] got [8];
        bit got_last [8];
        exp_b = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge i_clk);
        i_seed = 32'h0;
        i_payload_len = 11'd6;
        i_enable = 1'b1;
        capture(4, cycles, ok);
        for (int i = 0; i < 4; i++) begin
            got[i] = cap_data[i];
            got_last[i] = cap_last[i];
        end
        i_enable = 1'b0;
        @(negedge i_clk);
        capture(4, cycles, ok);
        for (int i = 0; i < 4; i++) begin
            got[i+4] = cap_data[i];
            got_last[i+4] = cap_last[i];
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_b[i] || got_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL drop_byte%0d: got %h last %b required %h last %b",
                         i, got[i], got_last[i], exp_b[i], (i == 7));
            end
        end
        count_idle(idle, busy_cnt);
        checks++;
        if (idle !== 40 || busy_cnt !== GAP_CYCLES || o_busy !== 1'b0 || o_frame_count !== 16'd4) begin
            errors++;
            $display("FAIL drop_end: got idle %0d busy_cycles %0d busy %b fc %h required 40 12 0 0004",
                     idle, busy_cnt, o_busy, o_frame_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [6];
        int cycles, idle, busy_cnt;
        bit ok;
        exp_b = '{8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00};
        @(negedge i_clk);
        force dut.r_frame_count = 16'hFFFE;
        @(negedge i_clk);
        @(negedge i_clk);
        release dut.r_frame_count;
        @(negedge i_clk);
        i_seed = 32'h0;
        i_payload_len = 11'd0;
        i_enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture(2, cycles, ok);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (cap_data[i] !== exp_b[2*f+i] || cap_last[i] !== (i == 1)) begin
                    errors++;
                    $display("FAIL b2b_frame%0d_byte%0d: got %h last %b required %h last %b",
                             f, i, cap_data[i], cap_last[i], exp_b[2*f+i], (i == 1));
                end
            end
            if (f == 2) i_enable = 1'b0;
            count_idle(idle, busy_cnt);
            checks++;
            if ((f < 2 && idle !== GAP_CYCLES) || (f == 2 && busy_cnt !== GAP_CYCLES)) begin
                errors++;
                $display("FAIL b2b_gap%0d: got idle %0d busy %0d required 12", f, idle, busy_cnt);
            end
        end
        checks++;
        if (o_frame_count !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_wrap_count: got %h required 0001", o_frame_count);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] exp_b [4];
        int cycles, idle, busy_cnt;
        bit ok;
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
        pulse_enable(32'h0, 11'd20);
        capture(7, cycles, ok);
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_lfsr_rst_seed, o_lfsr_enable, o_tdata, o_frame_count, o_lfsr_seed} !== '0) begin
            errors++;
            $display("FAIL areset_immediate: got v%b l%b b%b rs%b en%b d%h fc%h seed%h required all zero",
                     o_tvalid, o_tlast, o_busy, o_lfsr_rst_seed, o_lfsr_enable, o_tdata, o_frame_count, o_lfsr_seed);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: got busy %b valid %b required 0 0", o_busy, o_tvalid);
        end
        pulse_enable(32'h0, 11'd2);
        capture(4, cycles, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== exp_b[i] || cap_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL areset_restart_byte%0d: got %h last %b required %h last %b",
                         i, cap_data[i], cap_last[i], exp_b[i], (i == 3));
            end
        end
        count_idle(idle, busy_cnt);
        checks++;
        if (o_frame_count !== 16'd1) begin
            errors++;
            $display("FAIL areset_count: got %h required 0001", o_frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lockup_seed();
        test_backpressure();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
